// File: rtl/poly_eval_horner.sv
// Polynomial evaluator using Horner's method on one shared multiply/add
// datapath. Operands are entered one at a time with a Go press/release
// handshake: the coefficients a_DEGREE..a_0 come first, then x.
module poly_eval_horner #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2,
    parameter int SIGNED = 0
) (
    input  logic                          Clock,
    input  logic                          Resetn,
    input  logic                          Go,
    input  logic [WIDTH-1:0]              DataIn,
    output logic [$clog2(DEGREE+2)-1:0]   LoadIndex,
    output logic                          Busy,
    output logic [WIDTH-1:0]              DataResult,
    output logic                          ResultValid,
    output logic                          Overflow
);

    localparam int   LI_W = $clog2(DEGREE + 2);
    localparam logic SGN  = (SIGNED != 0);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_INIT = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_ADD  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // ops[k] holds a_(DEGREE-k) for k = 0..DEGREE, ops[DEGREE+1] holds x,
    // so the slot number is exactly the LoadIndex the operand arrived on.
    logic [WIDTH-1:0]   ops [DEGREE+2];
    logic [2:0]         state;
    logic [WIDTH-1:0]   acc;
    logic [LI_W-1:0]    cnt;
    logic               ovf_int;

    logic [WIDTH-1:0]   x_val;
    logic [WIDTH-1:0]   coef_i;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic               mul_ovf;
    logic               add_ovf;

    assign x_val = ops[DEGREE+1];
    assign Busy  = (state == S_INIT) || (state == S_MUL) ||
                   (state == S_ADD)  || (state == S_DONE);

    // Shared ALU: full-precision product/sum plus range checks. Operands are
    // sign-extended only in signed mode, so one datapath serves both modes.
    always_comb begin
        coef_i = '0;
        for (int k = 0; k <= DEGREE; k++)
            if (cnt == LI_W'(DEGREE - k)) coef_i = ops[k];
        prod    = {{WIDTH{SGN & acc[WIDTH-1]}}, acc} *
                  {{WIDTH{SGN & x_val[WIDTH-1]}}, x_val};
        sum     = {SGN & acc[WIDTH-1], acc} + {SGN & coef_i[WIDTH-1], coef_i};
        // Fits iff the upper half is the extension of the kept low half.
        mul_ovf = prod[2*WIDTH-1:WIDTH] != {WIDTH{SGN & prod[WIDTH-1]}};
        add_ovf = sum[WIDTH] != (SGN & sum[WIDTH-1]);
    end

    // Load handshake, Horner sequencing and result registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_LOAD;
            LoadIndex   <= '0;
            for (int k = 0; k < DEGREE + 2; k++) ops[k] <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovf_int     <= 1'b0;
            DataResult  <= '0;
            ResultValid <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            case (state)
                S_LOAD: if (Go) begin
                    for (int k = 0; k < DEGREE + 2; k++)
                        if (LoadIndex == LI_W'(k)) ops[k] <= DataIn;
                    ResultValid <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: if (!Go) begin
                    if (LoadIndex < LI_W'(DEGREE + 1)) begin
                        LoadIndex <= LoadIndex + 1'b1;
                        state     <= S_LOAD;
                    end else begin
                        state     <= S_INIT;
                    end
                end
                S_INIT: begin
                    acc     <= ops[0];
                    ovf_int <= 1'b0;
                    cnt     <= LI_W'(DEGREE - 1);
                    state   <= S_MUL;
                end
                S_MUL: begin
                    acc <= prod[WIDTH-1:0];
                    if (mul_ovf) ovf_int <= 1'b1;
                    state <= S_ADD;
                end
                S_ADD: begin
                    acc <= sum[WIDTH-1:0];
                    if (add_ovf) ovf_int <= 1'b1;
                    if (cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt - 1'b1;
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    DataResult  <= acc;
                    Overflow    <= ovf_int;
                    ResultValid <= 1'b1;
                    LoadIndex   <= '0;
                    state       <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: doc/poly_eval_horner.md
Name: poly_eval_horner

Overview:
- Parametrised polynomial evaluator: y = a_N·x^N + … + a_1·x + a_0, degree N = DEGREE, operand width WIDTH, signed or unsigned arithmetic.
- Operands are loaded serially from switch-style inputs with a Go press/release handshake.
- Evaluation uses Horner's method on a single shared multiply/add ALU, driven by an FSM plus a coefficient counter.
- Adds a sticky overflow flag and a busy indication.

Parameters:
- WIDTH, 8, bit width of DataIn, coefficients, x, accumulator and DataResult (2..16).
- DEGREE, 2, polynomial degree N; DEGREE+1 coefficients are stored (1..7).
- SIGNED, 0, 0 = unsigned arithmetic; 1 = two's-complement arithmetic and overflow detection.

Ports:
- Clock  input  1  single clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Go  input  1  operand-load strobe (level, press/release).
- DataIn  input  WIDTH  operand value (coefficient or x).
- LoadIndex  output  $clog2(DEGREE+2)  index of the operand expected next: 0..DEGREE = a_DEGREE..a_0, DEGREE+1 = x.
- Busy  output  1  high while evaluation is in progress.
- DataResult  output  WIDTH  registered result (truncated to WIDTH).
- ResultValid  output  1  DataResult holds a completed evaluation.
- Overflow  output  1  some intermediate of the last evaluation did not fit WIDTH bits.

Behaviour:
- Reset (Resetn low, asynchronous):
  - All outputs 0; coefficient regs, x and acc cleared.
  - FSM goes to LOAD with LoadIndex=0.
  - Takes effect mid-load or mid-compute; any partial evaluation is discarded.
- FSM states: LOAD, LOAD_WAIT, INIT, MUL, ADD, DONE.
- LOAD:
  - On the first rising edge with Go=1, capture DataIn into operand[LoadIndex] and go to LOAD_WAIT.
  - On the same edge, clear ResultValid.
- LOAD_WAIT:
  - Stay while Go=1.
  - On the edge where Go=0: if LoadIndex<DEGREE+1, increment LoadIndex and go to LOAD; else go to INIT.
- INIT: acc <= a_DEGREE; Overflow_int <= 0; i <= DEGREE-1; go to MUL.
- MUL: acc <= acc·x, truncated to WIDTH; go to ADD.
- ADD: acc <= acc + a_i, truncated; if i==0 go to DONE, else decrement i and go to MUL.
- DONE: DataResult <= acc; Overflow <= Overflow_int; ResultValid <= 1; LoadIndex <= 0; go to LOAD.
- Overflow_int is set in MUL or ADD when the full-precision result is outside range:
  - unsigned: [0, 2^WIDTH−1]
  - signed: [−2^(WIDTH−1), 2^(WIDTH−1)−1]
  - Products use a 2·WIDTH-bit intermediate; sums use WIDTH+1 bits.
- Latency: ResultValid rises exactly 2·DEGREE+2 rising edges after the edge that samples Go=0 in LOAD_WAIT for x.
- Busy: high in INIT, MUL, ADD, DONE; low otherwise.
- Go is ignored while Busy=1.
- DataResult and Overflow hold their values until the next DONE. ResultValid stays high until the first Go=1 sample in LOAD.
- DataIn is ignored except on capture edges.

Test Plan:
- WIDTH=8, DEGREE=2, SIGNED=0; load a2=2, a1=3, a0=4, x=5 -> DataResult=69 (0x45), Overflow=0, ResultValid high 6 edges after x release.
- Same config; a2=16, a1=0, a0=0, x=16 -> DataResult=0x00, Overflow=1; next run a2=1, a1=1, a0=1, x=2 -> 7, Overflow=0 (flag not sticky across runs).
- SIGNED=1, WIDTH=8, DEGREE=2; a2=0xFF (−1), a1=0, a0=3, x=2 -> DataResult=0xFF (−1), Overflow=0.
- DEGREE=1; a1=7, a0=1, x=9 -> 64 (0x40), ResultValid 4 edges after x release; Go held for 10 cycles per operand -> exactly one capture per press.
- Resetn pulsed low for 1 ns mid-MUL -> all outputs 0 immediately, LoadIndex=0, Busy=0; full reload afterwards gives the correct result.
- Go toggled during Busy -> no capture, LoadIndex unchanged; Go pressed after DONE -> ResultValid drops on that edge, DataResult keeps the old value.
